// File: rtl/extend_pkg.sv
// Shared definitions for the extend_pipe slice: extension mode encodings and
// the width-parametrised extension function used by the top level.
package extend_pkg;

   localparam logic [1:0] MODE_ZERO = 2'b00;
   localparam logic [1:0] MODE_SIGN = 2'b01;
   localparam logic [1:0] MODE_ONES = 2'b10;
   localparam logic [1:0] MODE_RSVD = 2'b11;

   // Widest word the extension function can handle; callers truncate the
   // result to their own output width.
   localparam int MAX_W = 64;

   // Extend the low in_w bits of data to out_w bits according to mode.
   // Bits at or above out_w are returned as zero. Reserved mode zero-fills.
   function automatic logic [MAX_W-1:0] ext(input logic [MAX_W-1:0] data,
                                            input logic [1:0]       mode,
                                            input int               in_w,
                                            input int               out_w);
      logic [MAX_W-1:0] res_s;
      logic             msb_s;
      logic             fill_s;
      res_s = {MAX_W{1'b0}};
      msb_s = 1'b0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i == in_w - 1) begin
            msb_s = data[i];
         end else begin
            msb_s = msb_s;
         end
      end
      case (mode)
         MODE_SIGN: fill_s = msb_s;
         MODE_ONES: fill_s = 1'b1;
         default:   fill_s = 1'b0;
      endcase
      for (int i = 0; i < MAX_W; i++) begin
         if (i < in_w) begin
            res_s[i] = data[i];
         end else if (i < out_w) begin
            res_s[i] = fill_s;
         end else begin
            res_s[i] = 1'b0;
         end
      end
      return res_s;
   endfunction

endpackage

// File: rtl/extend_fifo.sv
// Generic DEPTH x W synchronous FIFO. Head data is read straight from the
// storage array at the read pointer, so it holds steady until a pop.
// Occupancy lives in its own counter one bit wider than the pointers.
module extend_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign full      = (count_r == FULL_CNT);
   assign empty     = (count_r == {CW{1'b0}});
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;
   assign pop_data  = mem_r[rd_ptr_r];

   // Storage, pointers and occupancy; reset clears everything so no stale word survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {W{1'b0}};
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/extend_pipe.sv
// Pipelined data-extension unit: extends IN_W-bit words to OUT_W bits by
// mode and buffers the results in a DEPTH-entry output FIFO with
// valid/ready handshakes on both sides.
// Optional feature macro: EXTEND_STATS_EN adds the stat_neg counter/port.
module extend_pipe
   import extend_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_err
`ifdef EXTEND_STATS_EN
   ,
   output logic [15:0]      stat_neg
`endif
);

   logic [OUT_W-1:0] ext_s;
   logic             err_s;
   logic             accept_s;
   logic             deliver_s;
   logic             full_s;
   logic             empty_s;
   logic [OUT_W:0]   head_s;

   assign ext_s     = OUT_W'(ext(MAX_W'(in_data), in_mode, IN_W, OUT_W));
   assign err_s     = (in_mode == MODE_RSVD);
   // in_ready depends only on occupancy, never on out_ready.
   assign in_ready  = !full_s;
   assign out_valid = !empty_s;
   assign accept_s  = in_valid && in_ready;
   assign deliver_s = out_valid && out_ready;
   assign out_err   = head_s[OUT_W];
   assign out_data  = head_s[OUT_W-1:0];

   extend_fifo #(
      .W     (OUT_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (accept_s),
      .push_data ({err_s, ext_s}),
      .pop       (deliver_s),
      .pop_data  (head_s),
      .full      (full_s),
      .empty     (empty_s)
   );

`ifdef EXTEND_STATS_EN
   logic [15:0] stat_neg_r;
   logic        neg_hit_s;

   assign neg_hit_s = accept_s && (in_mode == MODE_SIGN) && in_data[IN_W-1];
   assign stat_neg  = stat_neg_r;

   // Saturating count of accepted negative sign-extends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_neg_r <= 16'h0000;
      end else if (neg_hit_s && (stat_neg_r != 16'hFFFF)) begin
         stat_neg_r <= stat_neg_r + 16'h0001;
      end else begin
         stat_neg_r <= stat_neg_r;
      end
   end
`endif

endmodule

// File: doc/extend_pipe.md
# extend_pipe

Parametrised, pipelined data-extension unit: the next generation of the 16→32 combinational extender. It accepts IN_W-bit words with a per-word extension mode and emits OUT_W-bit results through a valid/ready handshake. The results are buffered in a DEPTH-entry output FIFO. It sits between the decode/immediate path and any stalling downstream consumer, such as the ALU operand latch or the memory load aligner.

## Interface
- IN_W, 16, input word width; 1 ≤ IN_W ≤ OUT_W.
- OUT_W, 32, output word width.
- DEPTH, 4, output FIFO entries; power of two, ≥ 2.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input word present.
- in_ready  out  1  unit can accept a word this cycle.
- in_data  in  IN_W  word to extend.
- in_mode  in  2  00 zero-extend, 01 sign-extend, 10 ones-fill, 11 reserved.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head this cycle.
- out_data  out  OUT_W  extended word at FIFO head.
- out_err  out  1  head entry was submitted with reserved mode.
- stat_neg  out  16  saturating count of accepted sign-extends with in_data[IN_W-1]=1 (present only with EXTEND_STATS_EN).

## Operation
- Accept: transfer when in_valid && in_ready. Extension is computed combinationally from in_data/in_mode and written into the FIFO tail in the same edge.
- Zero mode: upper OUT_W-IN_W bits are 0.
- Sign mode: upper bits replicate in_data[IN_W-1].
- Ones mode: upper bits are 1.
- Reserved mode: data is zero-extended and the entry's err bit is set to 1.
- If IN_W == OUT_W, all modes pass data through unchanged. Reserved mode still sets err.
- Deliver: transfer when out_valid && out_ready. Head advances and the count decrements.
- Entries are delivered strictly in acceptance order. No word is dropped or duplicated.
- FIFO pointers are log2(DEPTH) bits wide and wrap naturally. Occupancy is held in a separate log2(DEPTH)+1-bit counter.
- in_ready = (count != DEPTH). When full, a simultaneous pop does not open in_ready in the same cycle; there is no combinational out_ready→in_ready path.
- out_valid = (count != 0). The empty FIFO has no bypass.
- Push and pop in the same cycle with 0 < count < DEPTH: count is unchanged, both pointers advance.
- in_data/in_mode are ignored while in_valid=0. A source may change them freely until acceptance.

## Timing
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N (cycle N+1), provided the FIFO was empty.
- Throughput: 1 word/cycle sustained when out_ready is held high.
- Reset (rst_n low, async): count=0, pointers=0, in_ready=1 one gate after release (it is a function of count only), out_valid=0, out_data=0, out_err=0, stat_neg=0.
- Reset mid-transfer: all buffered words are discarded. The first accept after rst_n rises is taken at the next rising edge.
- out_data/out_err are registered FIFO storage read at the head pointer. They are stable while out_valid && !out_ready.

## Configuration
- EXTEND_STATS_EN defined: the stat_neg port and 16-bit counter exist.
  - The counter increments on each accepted word with in_mode=01 and MSB=1.
  - It saturates at 16'hFFFF and resets to 0.
- EXTEND_STATS_EN undefined: no port, no counter. Datapath behaviour is identical.

## Structure
- extend_pkg holds:
  - mode localparams MODE_ZERO=2'b00, MODE_SIGN=2'b01, MODE_ONES=2'b10, MODE_RSVD=2'b11;
  - the extension function ext(data, mode), parametrised on widths.
- Sub-module extend_fifo: generic DEPTH×(OUT_W+1) synchronous FIFO with push/pop/full/empty/count. The err bit is stored as the MSB.
- The top-level extend_pipe holds the extension logic, handshake glue and the optional stats counter.

## Test plan
- Reset, then feed IN_W=16, OUT_W=32, out_ready=1:
  - a=16'h8000 sign → 32'hFFFF8000;
  - a=16'h8000 zero → 32'h00008000;
  - a=16'h0000 ones → 32'hFFFF0000;
  - a=16'hFFFF sign → 32'hFFFFFFFF.
  - Each appears one cycle after acceptance.
- Reserved mode, a=16'h1234 → out_data=32'h00001234, out_err=1. The next normal word has out_err=0.
- Hold out_ready=0 and push 4 words: in_ready drops after the 4th accept. The 5th word is held at the source. Release out_ready: words emerge in order, then the 5th is accepted.
- Full FIFO with in_valid=1 and out_ready=1 for one cycle: one pop occurs and no push. The next cycle accepts the push. Count never exceeds 4.
- Assert rst_n=0 with 3 words buffered: out_valid drops immediately and no stale word appears after release.
- With EXTEND_STATS_EN: 3 negative sign-extends plus 2 positive sign-extends → stat_neg=3. Preloaded to 16'hFFFF, the counter stays at FFFF.
